// File: rtl/ddr_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_cmd_pkg
//  Description : Shared definitions for the DDR command sequencer: one-hot
//                command bit positions, command vector width, sequencer
//                state encoding and small elaboration-time helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_cmd_pkg;

    localparam int CMD_WIDTH = 19;
    localparam int CMD_ACT   = 18;
    localparam int CMD_PR    = 7;
    localparam int CMD_RD    = 5;
    localparam int CMD_WR    = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACT       = 3'd1,
        ST_TRCD_WAIT = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_RD_DRAIN  = 3'd5,
        ST_PRE       = 3'd6,
        ST_TRP_WAIT  = 3'd7
    } seq_state_e;

    // One-hot command word with only bit idx set.
    function automatic logic [CMD_WIDTH-1:0] cmd_onehot(input int idx);
        logic [CMD_WIDTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_read_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_read_capture
//  Description : Delays each RD beat's slot index by RL cycles so the beat
//                is sampled from dq_in when the chip drives it, assembles the
//                BL beats into one burst word and pulses rd_valid the cycle
//                after the last beat lands. Everything freezes while halt=1.
//  Ports       : clk, rst (async, active-low), halt
//                beat_valid/beat_idx/beat_last : RD beat issued this cycle
//                dq_in      : read beat from the chip
//                rd_data    : assembled burst, beat 0 in LSBs
//                rd_valid   : registered completion pulse (unmasked)
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_read_capture
    import ddr_cmd_pkg::*;
#(
    parameter int BL           = 8,
    parameter int DEVICE_WIDTH = 4,
    parameter int RL           = 2,
    localparam int BEATW       = clog2_min1(BL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halt,
    input  logic                       beat_valid,
    input  logic [BEATW-1:0]           beat_idx,
    input  logic                       beat_last,
    input  logic [DEVICE_WIDTH-1:0]    dq_in,
    output logic [BL*DEVICE_WIDTH-1:0] rd_data,
    output logic                       rd_valid
);

    logic             w_cap_valid;
    logic             w_cap_last;
    logic [BEATW-1:0] w_cap_idx;

    generate
        if (RL == 0) begin : g_rl_direct
            // Chip answers in the same cycle as the RD beat.
            assign w_cap_valid = beat_valid;
            assign w_cap_idx   = beat_idx;
            assign w_cap_last  = beat_last;
        end else begin : g_rl_pipe
            logic             r_pipe_valid [RL];
            logic             r_pipe_last  [RL];
            logic [BEATW-1:0] r_pipe_idx   [RL];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < RL; k++) begin
                        r_pipe_valid[k] <= 1'b0;
                        r_pipe_last[k]  <= 1'b0;
                        r_pipe_idx[k]   <= '0;
                    end
                end else if (!halt) begin
                    r_pipe_valid[0] <= beat_valid;
                    r_pipe_last[0]  <= beat_last;
                    r_pipe_idx[0]   <= beat_idx;
                    for (int k = 1; k < RL; k++) begin
                        r_pipe_valid[k] <= r_pipe_valid[k-1];
                        r_pipe_last[k]  <= r_pipe_last[k-1];
                        r_pipe_idx[k]   <= r_pipe_idx[k-1];
                    end
                end
            end

            // Last stage lines up with the cycle the chip drives the beat.
            assign w_cap_valid = r_pipe_valid[RL-1];
            assign w_cap_idx   = r_pipe_idx[RL-1];
            assign w_cap_last  = r_pipe_last[RL-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (!halt) begin
            if (w_cap_valid) begin
                rd_data[w_cap_idx*DEVICE_WIDTH +: DEVICE_WIDTH] <= dq_in;
            end
            rd_valid <= w_cap_valid & w_cap_last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_cmd_sequencer
//  Description : Close-page DDR command sequencer. Takes one read or write
//                request at a time and runs ACT, tRCD wait, BL-beat RD/WR
//                burst, PR, tRP wait, producing one-hot commands, the per-beat
//                column stream and write data for the chip model.
//  Ports       : clk, rst (async, active-low), halt (freeze)
//                req_*     : request handshake and fields
//                rd_data/rd_valid : assembled read burst + completion pulse
//                commands  : one-hot ACT/PR/RD/WR (or zero)
//                bg/ba/row/column : chip address
//                dq_out/dq_in/dq_oe : data beat out/in, drive enable
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_cmd_sequencer
    import ddr_cmd_pkg::*;
#(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 2,
    parameter int BANKSPERGROUP = 2,
    parameter int DEVICE_WIDTH  = 4,
    parameter int COLS          = 1024,
    parameter int BL            = 8,
    parameter int TRCD          = 4,
    parameter int TRP           = 4,
    parameter int RL            = 2,
    localparam int BGWIDTH      = $clog2(BANKGROUPS),
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
    localparam int CADDRWIDTH   = $clog2(COLS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halt,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [BGWIDTH:0]           req_bg,
    input  logic [BAWIDTH:0]           req_ba,
    input  logic [ADDRWIDTH-1:0]       req_row,
    input  logic [CADDRWIDTH-1:0]      req_col,
    input  logic [BL*DEVICE_WIDTH-1:0] req_wdata,
    output logic [BL*DEVICE_WIDTH-1:0] rd_data,
    output logic                       rd_valid,
    output logic [CMD_WIDTH-1:0]       commands,
    output logic [BGWIDTH:0]           bg,
    output logic [BAWIDTH:0]           ba,
    output logic [ADDRWIDTH-1:0]       row,
    output logic [CADDRWIDTH-1:0]      column,
    output logic [DEVICE_WIDTH-1:0]    dq_out,
    input  logic [DEVICE_WIDTH-1:0]    dq_in,
    output logic                       dq_oe
);

    localparam int C_BEATW   = clog2_min1(BL);
    localparam int C_CNT_MAX = (TRCD > TRP) ? ((TRCD > RL) ? TRCD : RL)
                                            : ((TRP > RL) ? TRP : RL);
    localparam int C_CNTW    = clog2_min1(C_CNT_MAX + 1);

    // Wait counters count down to zero, so a wait of N cycles loads N-1.
    localparam logic [C_CNTW-1:0]  C_TRCD_LOAD = C_CNTW'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [C_CNTW-1:0]  C_TRP_LOAD  = C_CNTW'((TRP > 1) ? TRP - 2 : 0);
    localparam logic [C_CNTW-1:0]  C_RL_LOAD   = C_CNTW'((RL > 0) ? RL - 1 : 0);
    localparam logic [C_BEATW-1:0] C_LAST_BEAT = C_BEATW'(BL - 1);

    seq_state_e                r_state, w_state_nxt;
    logic [C_CNTW-1:0]         r_cnt, w_cnt_nxt;
    logic [C_BEATW-1:0]        r_beat, w_beat_nxt;

    logic                      r_we;
    logic [CADDRWIDTH-1:0]     r_col;
    logic [BL*DEVICE_WIDTH-1:0] r_wdata;

    logic [CMD_WIDTH-1:0]      r_cmd, w_cmd_nxt;
    logic [CADDRWIDTH-1:0]     r_column, w_column_nxt;
    logic [DEVICE_WIDTH-1:0]   r_dq_out, w_dq_out_nxt;
    logic                      r_dq_oe, w_dq_oe_nxt;
    logic                      r_ready, w_ready_nxt;
    logic                      w_cap_rd_valid;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
        end else if (!halt) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // -------------------------------------------- next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_state_nxt = ST_ACT;
            end
            ST_ACT: begin
                w_beat_nxt = '0;
                if (TRCD > 1) begin
                    w_state_nxt = ST_TRCD_WAIT;
                    w_cnt_nxt   = C_TRCD_LOAD;
                end else begin
                    w_state_nxt = r_we ? ST_WRITE : ST_READ;
                end
            end
            ST_TRCD_WAIT: begin
                if (r_cnt == '0) w_state_nxt = r_we ? ST_WRITE : ST_READ;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_WRITE: begin
                if (r_beat == C_LAST_BEAT) w_state_nxt = ST_PRE;
                else                       w_beat_nxt  = r_beat + 1'b1;
            end
            ST_READ: begin
                if (r_beat == C_LAST_BEAT) begin
                    if (RL > 0) begin
                        w_state_nxt = ST_RD_DRAIN;
                        w_cnt_nxt   = C_RL_LOAD;
                    end else begin
                        w_state_nxt = ST_PRE;
                    end
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            ST_RD_DRAIN: begin
                if (r_cnt == '0) w_state_nxt = ST_PRE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_PRE: begin
                if (TRP > 1) begin
                    w_state_nxt = ST_TRP_WAIT;
                    w_cnt_nxt   = C_TRP_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TRP_WAIT: begin
                if (r_cnt == '0) w_state_nxt = ST_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the upcoming state and registered, so
        // each command appears in the cycle its state occupies.
        w_cmd_nxt    = '0;
        w_column_nxt = r_column;
        w_dq_out_nxt = '0;
        w_dq_oe_nxt  = 1'b0;
        w_ready_nxt  = (w_state_nxt == ST_IDLE);
        case (w_state_nxt)
            ST_ACT:   w_cmd_nxt = cmd_onehot(CMD_ACT);
            ST_WRITE: begin
                w_cmd_nxt    = cmd_onehot(CMD_WR);
                w_column_nxt = r_col + CADDRWIDTH'(w_beat_nxt);
                w_dq_out_nxt = r_wdata[w_beat_nxt*DEVICE_WIDTH +: DEVICE_WIDTH];
                w_dq_oe_nxt  = 1'b1;
            end
            ST_READ: begin
                w_cmd_nxt    = cmd_onehot(CMD_RD);
                w_column_nxt = r_col + CADDRWIDTH'(w_beat_nxt);
            end
            ST_PRE:   w_cmd_nxt = cmd_onehot(CMD_PR);
            default:  w_cmd_nxt = '0;
        endcase
    end

    // ------------------------------------------- request latch and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            bg       <= '0;
            ba       <= '0;
            row      <= '0;
            r_col    <= '0;
            r_wdata  <= '0;
            r_cmd    <= '0;
            r_column <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_ready  <= 1'b1;
        end else if (!halt) begin
            if (r_state == ST_IDLE && req_valid) begin
                r_we    <= req_we;
                bg      <= req_bg;
                ba      <= req_ba;
                row     <= req_row;
                r_col   <= req_col;
                r_wdata <= req_wdata;
            end
            r_cmd    <= w_cmd_nxt;
            r_column <= w_column_nxt;
            r_dq_out <= w_dq_out_nxt;
            r_dq_oe  <= w_dq_oe_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    ddr_read_capture #(
        .BL           (BL),
        .DEVICE_WIDTH (DEVICE_WIDTH),
        .RL           (RL)
    ) u_read_capture (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .beat_valid (r_state == ST_READ),
        .beat_idx   (r_beat),
        .beat_last  (r_beat == C_LAST_BEAT),
        .dq_in      (dq_in),
        .rd_data    (rd_data),
        .rd_valid   (w_cap_rd_valid)
    );

    // Halt silences the bus immediately; the frozen registers replay the
    // same cycle once it drops.
    assign commands  = halt ? '0 : r_cmd;
    assign dq_oe     = r_dq_oe & ~halt;
    assign req_ready = r_ready & ~halt;
    assign rd_valid  = w_cap_rd_valid & ~halt;
    assign column    = r_column;
    assign dq_out    = r_dq_out;

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_cmd_sequencer
//  Description : Self-checking bench for ddr_cmd_sequencer. A reference model
//                derives the expected command timeline from the request
//                timing rules; a chip model stores written beats and returns
//                read beats RL cycles after each RD.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_cmd_sequencer;

    localparam int BL   = 8;
    localparam int TRCD = 4;
    localparam int TRP  = 4;
    localparam int RL   = 2;
    localparam int COLS = 1024;
    localparam int CW   = 10;
    localparam int DW   = 32;
    localparam int NCYC = 8192;

    localparam logic [18:0] T_ACT = 19'b1 << 18;
    localparam logic [18:0] T_PR  = 19'b1 << 7;
    localparam logic [18:0] T_RD  = 19'b1 << 5;
    localparam logic [18:0] T_WR  = 19'b1 << 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          halt = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [1:0]    req_bg = '0;
    logic [1:0]    req_ba = '0;
    logic [16:0]   req_row = '0;
    logic [CW-1:0] req_col = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    dq_in = '0;
    logic          req_ready, rd_valid, dq_oe;
    logic [DW-1:0] rd_data;
    logic [18:0]   commands;
    logic [1:0]    bg, ba;
    logic [16:0]   row;
    logic [CW-1:0] column;
    logic [3:0]    dq_out;

    always #5 clk = ~clk;

    ddr_cmd_sequencer u_dut (
        .clk (clk), .rst (rst), .halt (halt),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_bg (req_bg), .req_ba (req_ba), .req_row (req_row), .req_col (req_col),
        .req_wdata (req_wdata), .rd_data (rd_data), .rd_valid (rd_valid),
        .commands (commands), .bg (bg), .ba (ba), .row (row), .column (column),
        .dq_out (dq_out), .dq_in (dq_in), .dq_oe (dq_oe)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Expected timeline, indexed by non-halted cycle number.
    logic [18:0]   e_cmd   [NCYC];
    logic [CW-1:0] e_col   [NCYC];
    logic [3:0]    e_dq    [NCYC];
    bit            e_oe    [NCYC];
    bit            e_rv    [NCYC];
    logic [DW-1:0] e_rdata [NCYC];
    logic [20:0]   e_addr  [NCYC];
    logic [3:0]    dq_sched[NCYC];
    logic [3:0]    chip_mem[int];
    logic [3:0]    ref_mem [int];

    int ac      = 0;
    int free_at = 0;
    int n_acc   = 0;
    int acc_at  = 0;
    int mon_key;
    bit mon_en  = 1'b0;

    function automatic int key(input logic [1:0] b, input logic [1:0] a,
                               input logic [16:0] r, input logic [CW-1:0] c);
        return int'({1'b0, b, a, r, c});
    endfunction

    // Content of a never-written location, identical for chip and reference.
    function automatic logic [3:0] mem_default(input int k);
        logic [31:0] v;
        v = k;
        return v[3:0] ^ v[13:10] ^ v[20:17];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NCYC; i++) begin
            e_cmd[i] = '0; e_col[i] = '0; e_dq[i] = '0; e_oe[i] = 1'b0;
            e_rv[i] = 1'b0; e_rdata[i] = '0; e_addr[i] = '0; dq_sched[i] = '0;
        end
        chip_mem.delete();
        ref_mem.delete();
        free_at = ac;
    endtask

    // Request accepted in cycle t: lay out its whole timeline.
    task automatic model_accept(input int t);
        int            c, pr, colv, k;
        logic [DW-1:0] rdat;
        logic [20:0]   ad;
        ad   = {req_bg, req_ba, req_row};
        rdat = '0;
        e_cmd[t+1]  = T_ACT;
        e_addr[t+1] = ad;
        for (int i = 0; i < BL; i++) begin
            c    = t + 1 + TRCD + i;
            colv = (int'(req_col) + i) % COLS;
            e_cmd[c]  = req_we ? T_WR : T_RD;
            e_col[c]  = CW'(colv);
            e_addr[c] = ad;
            k = key(req_bg, req_ba, req_row, CW'(colv));
            if (req_we) begin
                e_dq[c]    = req_wdata[i*4 +: 4];
                e_oe[c]    = 1'b1;
                ref_mem[k] = req_wdata[i*4 +: 4];
            end else begin
                rdat[i*4 +: 4] = ref_mem.exists(k) ? ref_mem[k] : mem_default(k);
            end
        end
        pr = t + TRCD + BL + 1 + (req_we ? 0 : RL);
        e_cmd[pr]  = T_PR;
        e_addr[pr] = ad;
        if (!req_we) begin
            e_rv[pr]    = 1'b1;
            e_rdata[pr] = rdat;
        end
        free_at = pr + TRP;
        acc_at  = t;
        n_acc++;
    endtask

    // Per-cycle comparison plus the chip model, which halts in lockstep.
    always @(negedge clk) begin
        if (mon_en) begin
            if (halt) begin
                check_val("halt_cmd", commands, 0);
                check_val("halt_oe", dq_oe, 0);
                check_val("halt_rv", rd_valid, 0);
                check_val("halt_ready", req_ready, 0);
            end else begin
                check_val("ready", req_ready, ac >= free_at);
                check_val("cmd", commands, e_cmd[ac]);
                check_val("dq_oe", dq_oe, e_oe[ac]);
                check_val("rd_valid", rd_valid, e_rv[ac]);
                if (e_cmd[ac] != '0) check_val("addr", {bg, ba, row}, e_addr[ac]);
                if (e_cmd[ac] == T_WR || e_cmd[ac] == T_RD) check_val("column", column, e_col[ac]);
                if (e_oe[ac]) check_val("dq_out", dq_out, e_dq[ac]);
                if (e_rv[ac]) check_val("rd_data", rd_data, e_rdata[ac]);
                if (commands == T_WR) begin
                    mon_key = key(bg, ba, row, column);
                    chip_mem[mon_key] = dq_out;
                end
                if (commands == T_RD) begin
                    mon_key = key(bg, ba, row, column);
                    dq_sched[ac+RL] = chip_mem.exists(mon_key) ? chip_mem[mon_key] : mem_default(mon_key);
                end
                dq_in = dq_sched[ac];
                if (ac >= free_at && req_valid) model_accept(ac);
                ac++;
            end
        end
    end

    task automatic send_req(input bit we, input logic [1:0] b, input logic [1:0] a,
                            input logic [16:0] r, input logic [CW-1:0] c, input logic [DW-1:0] wd);
        int start;
        req_we = we; req_bg = b; req_ba = a; req_row = r; req_col = c; req_wdata = wd;
        req_valid = 1'b1;
        start = n_acc;
        for (int w = 0; w < 200 && n_acc == start; w++) @(posedge clk) #1;
        if (n_acc == start) check_val("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 200 && ac < free_at; w++) @(posedge clk) #1;
        if (ac < free_at) check_val("idle_timeout", 0, 1);
        @(posedge clk) #1;
    endtask

    task automatic wait_cycle(input int target);
        for (int w = 0; w < 200 && ac != target; w++) @(posedge clk) #1;
        if (ac != target) check_val("cycle_timeout", ac, target);
    endtask

    initial begin
        int start;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cmd", commands, 0);
        check_val("rst_oe", dq_oe, 0);
        check_val("rst_rv", rd_valid, 0);
        check_val("rst_rdata", rd_data, 0);
        check_val("rst_addr", {bg, ba, row, column, dq_out}, 0);
        rst = 1'b1;
        clear_model();
        mon_en = 1'b1;
        @(posedge clk) #1;

        // Directed write then read-back at row 1 col 1.
        send_req(1'b1, 2'd0, 2'd0, 17'd1, 10'd1, 32'h98765432);
        wait_idle();
        send_req(1'b0, 2'd0, 2'd0, 17'd1, 10'd1, 32'h0);
        wait_idle();
        check_val("rd_burst", rd_data, 32'h98765432);

        // Column wrap within a burst.
        send_req(1'b1, 2'd1, 2'd1, 17'd5, 10'd1020, 32'hA1B2C3D4);
        wait_idle();
        send_req(1'b0, 2'd1, 2'd1, 17'd5, 10'd1020, 32'h0);
        wait_idle();
        check_val("wrap_burst", rd_data, 32'hA1B2C3D4);

        // Halt for three cycles on write beat 4.
        send_req(1'b1, 2'd0, 2'd1, 17'd9, 10'd100, 32'h13572468);
        wait_cycle(acc_at + 1 + TRCD + 4);
        halt = 1'b1;
        repeat (3) @(posedge clk) #1;
        halt = 1'b0;
        wait_idle();
        send_req(1'b0, 2'd0, 2'd1, 17'd9, 10'd100, 32'h0);
        wait_cycle(acc_at + 1 + TRCD + 6);
        halt = 1'b1;
        repeat (2) @(posedge clk) #1;
        halt = 1'b0;
        wait_idle();
        check_val("halt_burst", rd_data, 32'h13572468);

        // req_valid held through two requests.
        req_we = 1'b1; req_bg = 2'd1; req_ba = 2'd0; req_row = 17'd2;
        req_col = 10'd7; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        start = n_acc;
        for (int w = 0; w < 200 && n_acc < start + 2; w++) @(posedge clk) #1;
        check_val("held_valid_accepts", n_acc - start, 2);
        req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a write burst.
        send_req(1'b1, 2'd1, 2'd1, 17'd3, 10'd50, 32'h55AA55AA);
        wait_cycle(acc_at + 1 + TRCD + 2);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check_val("midrst_cmd", commands, 0);
        check_val("midrst_oe", dq_oe, 0);
        @(posedge clk) #1;
        rst = 1'b1;
        #1;
        check_val("midrst_ready", req_ready, 1);
        clear_model();
        mon_en = 1'b1;
        @(posedge clk) #1;

        // Random traffic with random halts and fields changing every cycle.
        for (int n = 0; n < 1500; n++) begin
            halt      = ($urandom_range(0, 11) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_bg    = 2'($urandom_range(0, 1));
            req_ba    = 2'($urandom_range(0, 1));
            req_row   = 17'($urandom_range(0, 3));
            req_col   = ($urandom_range(0, 3) == 0) ? CW'(1016 + $urandom_range(0, 7))
                                                    : CW'($urandom_range(0, 1023));
            req_wdata = $urandom;
            @(posedge clk) #1;
        end
        halt = 1'b0;
        req_valid = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk) #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_cmd_sequencer.md
# ddr_cmd_sequencer

Controller-side command sequencer that drives a DDR chip model's command/address/data interface. Accepts one read or write request at a time and runs a close-page sequence: ACT, tRCD wait, BL-beat WR or RD burst, PR, tRP wait. Sits between the emulator's request source and the chip model, producing the exact one-hot command encoding and beat-by-beat column/data stream the chip consumes.

## Interface
- ADDRWIDTH, 17, row address width
- BANKGROUPS, 2, bank groups (BGWIDTH = clog2)
- BANKSPERGROUP, 2, banks per group (BAWIDTH = clog2)
- DEVICE_WIDTH, 4, DQ bits per beat
- COLS, 1024, columns per row (CADDRWIDTH = clog2)
- BL, 8, beats per burst
- TRCD, 4, cycles from ACT cycle to first RD/WR beat (≥1)
- TRP, 4, cycles from PR cycle to next ACT opportunity (≥1)
- RL, 2, cycles from an RD beat to its data on dq_in (≥0)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- halt  in  1  freeze everything while 1
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, accepts request
- req_we  in  1  1 = write, 0 = read
- req_bg  in  BGWIDTH+1  bank group
- req_ba  in  BAWIDTH+1  bank
- req_row  in  ADDRWIDTH  row
- req_col  in  CADDRWIDTH  start column
- req_wdata  in  BL*DEVICE_WIDTH  write burst, beat 0 in LSBs
- rd_data  out  BL*DEVICE_WIDTH  read burst, beat 0 in LSBs
- rd_valid  out  1  one-cycle pulse, rd_data complete
- commands  out  19  one-hot: ACT=bit18, PR=bit7, RD=bit5, WR=bit1
- bg, ba, row, column  out  chip widths  address to chip
- dq_out  out  DEVICE_WIDTH  write beat
- dq_in  in  DEVICE_WIDTH  read beat from chip
- dq_oe  out  1  drive dq, dqs_t=1, dqs_c=0 (tristate at top level)

## Operation
- States: IDLE, ACT, TRCD_WAIT, WRITE, READ, RD_DRAIN, PRE, TRP_WAIT.
- IDLE: req_ready=1; on req_valid latch all req_* fields, go ACT. req_ready=0 outside IDLE.
- ACT: commands=ACT, bg/ba/row driven (hold until PRE done); then TRCD_WAIT for TRCD-1 cycles (commands=0).
- WRITE/READ: BL cycles, beat i: commands=WR or RD, column=(req_col+i) mod COLS; write: dq_oe=1, dq_out=beat i.
- Read capture: beat i sampled from dq_in RL cycles after its RD cycle into rd_data slot i. RD_DRAIN holds RL cycles after last RD beat; rd_valid pulses the cycle after last capture, concurrent with PRE.
- PRE: commands=PR one cycle; TRP_WAIT TRP-1 cycles; then IDLE.
- Outputs registered; commands exactly one-hot or zero; never two bits.
- Reset (async, rst=0): state IDLE, commands=0, bg/ba/row/column=0, dq_out=0, dq_oe=0, rd_data=0, rd_valid=0, req_ready=1 after release.

## Timing
- Request accepted cycle t; ACT at t+1; first beat t+1+TRCD; last beat t+TRCD+BL.
- Write: PR at t+TRCD+BL+1; req_ready again at t+TRCD+BL+TRP+1.
- Read: PR and rd_valid at t+TRCD+BL+RL+1; req_ready at t+TRCD+BL+RL+TRP+1.
- halt=1: state, counters, capture pipeline frozen; commands=0, dq_oe=0, rd_valid=0, req_ready=0; resumes same cycle position on release. The chip halts in lockstep.
- Column wraps COLS-1 → 0 within burst.
- req_valid during busy ignored (not latched); req fields may change after acceptance.
- rst mid-burst: immediate return to reset values, no PR issued.

## Structure
- Package ddr_cmd_pkg: command bit indices (CMD_ACT=18, CMD_PR=7, CMD_RD=5, CMD_WR=1), command vector width 19, state enum.
- Sub-module ddr_read_capture: RL-deep beat-index/valid delay line plus BL-slot assembly register and rd_valid generation.

## Test plan
- Reset: rst=0 mid-write → commands=0, dq_oe=0 same cycle; req_ready=1 after release.
- Write row 1 col 1, wdata beats 2,3,...,9: ACT at t+1, WR cols 1..8 at t+5..t+12 with dq_out 2..9, PR at t+13, req_ready at t+17.
- Read same address, chip model returns written data: rd_valid at t+15 with identical 32-bit burst, PR same cycle.
- Column wrap: req_col=1020 → columns 1020..1023,0..3.
- halt=1 for 3 cycles during beat 4: beats resume at 4, all later events shifted exactly 3 cycles, no command during halt.
- req_valid held high during busy: exactly one ACT per accepted request, second accepted only when req_ready=1.
